// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl -- responder side of the MEM-stage memory request interface.
//
// Accepts one load or store request and performs it on a byte-wide synchronous
// RAM, one byte per cycle, little-endian. The pipeline is stalled for the whole
// access, and a load returns its sign/zero-extended result to writeback as a
// one-cycle pulse.
//
// Optional feature: define MEM_CTRL_ALIGN_CHK_EN to reject misaligned
// half-word/word requests. They finish in one DONE cycle with no RAM traffic
// and pulse misalign_o. Without the macro misalign_o is tied to 0 and
// misaligned requests proceed byte-serially like aligned ones.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   mem_ce_i          request valid
//   mem_we_i          1 = store, 0 = load
//   mem_addr_i        32-bit byte address
//   mem_data_i        store data
//   opcode_i          15 lb, 16 lh, 17 lw, 18 lbu, 19 lhu, 20 sb, 21 sh, 22 sw
//   mem_wd_i          load destination register
//   stall_req_o       hold the pipeline
//   ram_addr_o        RAM byte address (low RAM_ADDR_W bits)
//   ram_data_o        RAM write byte
//   ram_wr_o          RAM write strobe
//   ram_data_i        RAM read byte, valid the cycle after its address
//   wreg_o, wd_o      load result valid pulse and destination register
//   wdata_o           extended load data
//   misalign_o        misaligned-access pulse
// -----------------------------------------------------------------------------
module mem_ctrl #(
  parameter int RAM_ADDR_W = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_ce_i,
  input  logic                  mem_we_i,
  input  logic [31:0]           mem_addr_i,
  input  logic [31:0]           mem_data_i,
  input  logic [6:0]            opcode_i,
  input  logic [4:0]            mem_wd_i,
  output logic                  stall_req_o,
  output logic [RAM_ADDR_W-1:0] ram_addr_o,
  output logic [7:0]            ram_data_o,
  output logic                  ram_wr_o,
  input  logic [7:0]            ram_data_i,
  output logic                  wreg_o,
  output logic [4:0]            wd_o,
  output logic [31:0]           wdata_o,
  output logic                  misalign_o
);

  localparam logic [6:0] OP_LB  = 7'd15;
  localparam logic [6:0] OP_LH  = 7'd16;
  localparam logic [6:0] OP_LBU = 7'd18;
  localparam logic [6:0] OP_LHU = 7'd19;
  localparam logic [6:0] OP_SB  = 7'd20;
  localparam logic [6:0] OP_SH  = 7'd21;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_WAIT, ST_DONE} state_e;

  // Access size in bytes; lw/sw and any unrecognised opcode move a full word.
  function automatic logic [2:0] size_of(input logic [6:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 3'd1;
      OP_LH, OP_LHU, OP_SH: return 3'd2;
      default:              return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [6:0] op, input logic [31:0] w);
    case (op)
      OP_LB:   return {{24{w[7]}}, w[7:0]};
      OP_LH:   return {{16{w[15]}}, w[15:0]};
      OP_LBU:  return {24'd0, w[7:0]};
      OP_LHU:  return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction

  state_e                state_q;
  logic [2:0]            idx_q;
  logic [2:0]            n_q;
  logic [31:0]           addr_q;
  logic [31:0]           data_q;
  logic [31:0]           asm_q;
  logic [6:0]            op_q;
  logic                  we_q;
  logic [4:0]            wd_q;

  logic [RAM_ADDR_W-1:0] ram_addr_q;
  logic [7:0]            ram_data_q;
  logic                  ram_wr_q;
  logic                  wreg_q;
  logic [4:0]            wd_out_q;
  logic [31:0]           wdata_q;

  logic [2:0]            n_in;
  logic [1:0]            nxt_idx;
  logic [31:0]           nxt_addr;
  logic [31:0]           asm_d;
  logic                  last_beat;
  logic                  addr_hi_unused;

  assign n_in      = size_of(opcode_i);
  assign last_beat = (idx_q == n_q - 3'd1);

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    nxt_idx  = idx_q[1:0] + 2'd1;
    // 32-bit add wraps modulo 2^32 before the RAM address is truncated.
    nxt_addr = addr_q + {30'd0, nxt_idx};
    // The byte on ram_data_i belongs to the address issued one cycle earlier,
    // i.e. byte idx-1. In WAIT idx equals n, so the same rule lands the last
    // byte; idx=4 wraps to 0 in two bits and 0-1 selects byte 3.
    asm_d = asm_q;
    asm_d[{idx_q[1:0] - 2'd1, 3'b000} +: 8] = ram_data_i;
  end

  assign addr_hi_unused = ^nxt_addr[31:RAM_ADDR_W];

  // Stall is combinational in IDLE so a new request freezes the pipeline in
  // its accept cycle; gated by rst so every output reads 0 during reset.
  always_comb begin
    stall_req_o = 1'b0;
    case (state_q)
      ST_IDLE:          stall_req_o = mem_ce_i & rst;
      ST_BUSY, ST_WAIT: stall_req_o = 1'b1;
      default:          stall_req_o = 1'b0;
    endcase
  end

`ifdef MEM_CTRL_ALIGN_CHK_EN
  logic misalign_q;
  logic misaligned_in;
  assign misaligned_in = ((n_in == 3'd2) && mem_addr_i[0]) ||
                         ((n_in == 3'd4) && (mem_addr_i[1:0] != 2'b00));
  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

  // RAM and writeback outputs are registered: each transition loads the
  // values the next state must present.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= 3'd0;
      n_q        <= 3'd0;
      addr_q     <= 32'd0;
      data_q     <= 32'd0;
      asm_q      <= 32'd0;
      op_q       <= 7'd0;
      we_q       <= 1'b0;
      wd_q       <= 5'd0;
      ram_addr_q <= '0;
      ram_data_q <= 8'd0;
      ram_wr_q   <= 1'b0;
      wreg_q     <= 1'b0;
      wd_out_q   <= 5'd0;
      wdata_q    <= 32'd0;
`ifdef MEM_CTRL_ALIGN_CHK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mem_ce_i) begin
            addr_q <= mem_addr_i;
            data_q <= mem_data_i;
            op_q   <= opcode_i;
            we_q   <= mem_we_i;
            wd_q   <= mem_wd_i;
            n_q    <= n_in;
            idx_q  <= 3'd0;
            asm_q  <= 32'd0;
`ifdef MEM_CTRL_ALIGN_CHK_EN
            if (misaligned_in) begin
              misalign_q <= 1'b1;
              state_q    <= ST_DONE;
            end else
`endif
            begin
              state_q    <= ST_BUSY;
              ram_addr_q <= mem_addr_i[RAM_ADDR_W-1:0];
              ram_wr_q   <= mem_we_i;
              ram_data_q <= mem_we_i ? mem_data_i[7:0] : 8'd0;
            end
          end
        end

        ST_BUSY: begin
          if (idx_q != 3'd0) asm_q <= asm_d;
          idx_q <= idx_q + 3'd1;
          if (last_beat) begin
            ram_addr_q <= '0;
            ram_wr_q   <= 1'b0;
            ram_data_q <= 8'd0;
            // A load still owes one read byte, which arrives during WAIT.
            state_q    <= we_q ? ST_DONE : ST_WAIT;
          end else begin
            ram_addr_q <= nxt_addr[RAM_ADDR_W-1:0];
            ram_data_q <= we_q ? data_q[{nxt_idx, 3'b000} +: 8] : 8'd0;
          end
        end

        ST_WAIT: begin
          asm_q    <= asm_d;
          wreg_q   <= 1'b1;
          wd_out_q <= wd_q;
          wdata_q  <= extend(op_q, asm_d);
          state_q  <= ST_DONE;
        end

        ST_DONE: begin
          // The request is still on the inputs this cycle, so mem_ce_i is
          // deliberately ignored here.
          wreg_q   <= 1'b0;
          wd_out_q <= 5'd0;
          wdata_q  <= 32'd0;
`ifdef MEM_CTRL_ALIGN_CHK_EN
          misalign_q <= 1'b0;
`endif
          state_q  <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ram_addr_o = ram_addr_q;
  assign ram_data_o = ram_data_q;
  assign ram_wr_o   = ram_wr_q;
  assign wreg_o     = wreg_q;
  assign wd_o       = wd_out_q;
  assign wdata_o    = wdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl -- scoreboard bench for mem_ctrl. A byte-array RAM model sits on
// the RAM port. The driver computes each request's expected outcome from a
// reference memory (byte writes, little-endian loads, arithmetic extension)
// and queues it; a monitor on the falling edge compares RAM writes and
// DONE-cycle results against those queues.
// -----------------------------------------------------------------------------
module tb_mem_ctrl;

  localparam int AW = 17;
  localparam logic [31:0] AMASK = 32'h0001_FFFF;

  localparam logic [6:0] LB = 7'd15, LH = 7'd16, LW = 7'd17, LBU = 7'd18,
                         LHU = 7'd19, SB = 7'd20, SH = 7'd21, SW = 7'd22;

  typedef struct {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  typedef struct {
    bit          is_load;
    bit          misalign;
    logic [4:0]  wd;
    logic [31:0] wdata;
    int          latency;
  } txn_t;

  logic clk, rst;
  logic mem_ce_i, mem_we_i;
  logic [31:0] mem_addr_i, mem_data_i;
  logic [6:0] opcode_i;
  logic [4:0] mem_wd_i;
  logic stall_req_o;
  logic [AW-1:0] ram_addr_o;
  logic [7:0] ram_data_o, ram_data_i;
  logic ram_wr_o, wreg_o, misalign_o;
  logic [4:0] wd_o;
  logic [31:0] wdata_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  wr_t  wq[$];
  txn_t txq[$];
  logic [7:0] ref_mem [int unsigned];

  bit [7:0] ram [0:(1<<AW)-1];
  bit [7:0] ram_rd_q;

  logic [6:0] ld_ops [6] = '{LB, LH, LW, LBU, LHU, 7'd3};
  logic [6:0] st_ops [4] = '{SB, SH, SW, 7'd100};

  mem_ctrl #(.RAM_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i), .opcode_i(opcode_i), .mem_wd_i(mem_wd_i),
    .stall_req_o(stall_req_o), .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
    .ram_wr_o(ram_wr_o), .ram_data_i(ram_data_i), .wreg_o(wreg_o),
    .wd_o(wd_o), .wdata_o(wdata_o), .misalign_o(misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous byte RAM: read data appears the cycle after the address.
  always @(posedge clk) begin
    if (ram_wr_o) ram[ram_addr_o] <= ram_data_o;
    ram_rd_q <= ram[ram_addr_o];
  end
  assign ram_data_i = ram_rd_q;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [6:0] op);
    if (op == LB || op == LBU || op == SB) return 1;
    if (op == LH || op == LHU || op == SH) return 2;
    return 4;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    int unsigned k;
    k = a & AMASK;
    return ref_mem.exists(k) ? ref_mem[k] : 8'd0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [6:0] op, input logic [31:0] addr);
    longint v;
    int n;
    logic [31:0] a;
    v = 0;
    n = size_of(op);
    for (int i = 0; i < n; i++) begin
      a = addr + i;
      v += longint'(ref_byte(a)) << (8 * i);
    end
    if (op == LB && v >= 128)   v -= 256;
    if (op == LH && v >= 32768) v -= 65536;
    return v[31:0];
  endfunction

  // Queue expectations for a request, then drive it and hold it until the
  // DONE cycle (stall released while the request is still presented).
  task automatic issue(input logic we, input logic [6:0] op, input logic [31:0] addr,
                       input logic [31:0] data, input logic [4:0] wd);
    txn_t t;
    int n, seen;
    logic [31:0] a;
    n = size_of(op);
    t.misalign = 1'b0;
`ifdef MEM_CTRL_ALIGN_CHK_EN
    t.misalign = (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
`endif
    t.is_load = !we && !t.misalign;
    t.wd = wd;
    t.wdata = 32'd0;
    if (t.misalign) t.latency = 1;
    else if (we) begin
      t.latency = n + 1;
      for (int i = 0; i < n; i++) begin
        wr_t w;
        a = (addr + i) & AMASK;
        w.a = a[AW-1:0];
        w.d = 8'((data >> (8 * i)) & 32'hFF);
        wq.push_back(w);
        ref_mem[a] = w.d;
      end
    end else begin
      t.latency = n + 2;
      t.wdata = ref_load(op, addr);
    end
    txq.push_back(t);

    mem_ce_i = 1'b1; mem_we_i = we; opcode_i = op;
    mem_addr_i = addr; mem_data_i = data; mem_wd_i = wd;
    seen = 0;
    do begin
      @(negedge clk);
      seen++;
    end while (stall_req_o && seen < 40);
    if (stall_req_o) check("done_timeout", 1, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    mem_ce_i = 1'b0;
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"},    stall_req_o, 0);
    check({tag, "_ram_addr"}, ram_addr_o,  0);
    check({tag, "_ram_data"}, ram_data_o,  0);
    check({tag, "_ram_wr"},   ram_wr_o,    0);
    check({tag, "_wreg"},     wreg_o,      0);
    check({tag, "_wd"},       wd_o,        0);
    check({tag, "_wdata"},    wdata_o,     0);
    check({tag, "_misalign"}, misalign_o,  0);
  endtask

  // ---------------- monitor ----------------
  bit mon_busy = 0;
  int mon_start = 0;

  always @(negedge clk) begin
    if (!rst) begin
      mon_busy = 0;
    end else begin
      if (ram_wr_o) begin
        if (wq.size() == 0) check("unexpected_write", 1, 0);
        else begin
          wr_t w;
          w = wq.pop_front();
          check("wr_addr", ram_addr_o, w.a);
          check("wr_data", ram_data_o, w.d);
        end
      end
      if (mon_busy && !stall_req_o) begin
        mon_busy = 0;
        if (txq.size() == 0) check("unexpected_done", 1, 0);
        else begin
          txn_t t;
          t = txq.pop_front();
          check("latency", cyc - mon_start, t.latency);
          check("done_wreg", wreg_o, t.is_load);
          check("done_misalign", misalign_o, t.misalign);
          if (t.is_load) begin
            check("wd", wd_o, t.wd);
            check("wdata", wdata_o, t.wdata);
          end
        end
      end else begin
        check("quiet_outputs", {wreg_o, misalign_o, wd_o, wdata_o}, 0);
        if (!mon_busy && stall_req_o) begin
          mon_busy = 1;
          mon_start = cyc;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    mem_ce_i = 1'b1; mem_we_i = 1'b0; opcode_i = LW;
    mem_addr_i = 32'd0; mem_data_i = 32'd0; mem_wd_i = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    mem_ce_i = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    idle(1);

    // Directed scenarios
    issue(1'b1, SW, 32'h100, 32'hA1B2C3D4, 5'd0);
    issue(1'b1, SW, 32'h200, 32'h3412FF80, 5'd0);
    idle(1);
    issue(1'b0, LW,  32'h200, 32'd0, 5'd5);
    issue(1'b0, LB,  32'h200, 32'd0, 5'd6);
    issue(1'b0, LBU, 32'h200, 32'd0, 5'd7);
    issue(1'b0, LH,  32'h200, 32'd0, 5'd8);
    issue(1'b0, LHU, 32'h202, 32'd0, 5'd9);
    issue(1'b1, SH,  32'h301, 32'h0000BEEF, 5'd0);
    issue(1'b0, LHU, 32'h301, 32'd0, 5'd10);
    // lw then sb with mem_ce_i never dropping in between
    issue(1'b0, LW, 32'h100, 32'd0, 5'd11);
    issue(1'b1, SB, 32'h104, 32'h0000005A, 5'd0);
    // Address wrap across 2^32 and the RAM window
    issue(1'b1, SW, 32'hFFFF_FFFE, 32'hCAFEF00D, 5'd0);
    issue(1'b0, LW, 32'hFFFF_FFFE, 32'd0, 5'd12);
    idle(2);

    // Reset during the third BUSY cycle of sw 0x400: only two bytes land.
    begin
      wr_t w;
      w.a = 17'h400; w.d = 8'h11; wq.push_back(w); ref_mem[32'h400] = 8'h11;
      w.a = 17'h401; w.d = 8'h22; wq.push_back(w); ref_mem[32'h401] = 8'h22;
      mem_ce_i = 1'b1; mem_we_i = 1'b1; opcode_i = SW;
      mem_addr_i = 32'h400; mem_data_i = 32'h44332211; mem_wd_i = 5'd0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #1 check_all_zero("midreset");
      mem_ce_i = 1'b0;
      repeat (2) @(posedge clk);
      check("midreset_writes_left", wq.size(), 0);
      #1 rst = 1'b1;
      idle(1);
    end
    issue(1'b0, LW, 32'h400, 32'd0, 5'd13);

    // Randomized traffic
    for (int k = 0; k < 250; k++) begin
      logic we;
      logic [6:0] op;
      logic [31:0] a, d;
      we = 1'($urandom_range(0, 1));
      op = we ? st_ops[$urandom_range(0, 3)] : ld_ops[$urandom_range(0, 5)];
      if ($urandom_range(0, 3) == 0) a = $urandom();
      else a = 32'h500 + $urandom_range(0, 63);
      d = $urandom();
      issue(we, op, a, d, 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end

    idle(4);
    check("pending_writes", wq.size(), 0);
    check("pending_txns", txq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
